// File: rtl/mag_sq.sv
`timescale 1ns/1ps
// mag_sq
// Sequential sum-of-squares unit: mag = x*x + y*y, computed with one shared
// shift-add squarer. The squarer takes one step per clock, IN_W steps for
// |x| and then IN_W steps for |y|, so a result is ready 2*IN_W clocks after
// the accept edge. It produces the magnitude-squared input for the integer
// square-root block and uses the same go/done handshake as the other
// arithmetic blocks.
//
// Ports
//   clk    clock, all state updates on the rising edge
//   rst_n  synchronous active-low reset, aborts any operation in flight
//   x, y   signed components, sampled only on the accepting edge
//   go     start request, honoured only when the unit is idle
//   mag    unsigned x*x + y*y, registered, held until the next completion
//   done   registered one-cycle pulse marking a new mag value
//   busy   high while the squarer is stepping (SQX and SQY)
module mag_sq #(
   parameter int IN_W = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic signed [IN_W-1:0] x,
   input  logic signed [IN_W-1:0] y,
   input  logic                   go,
   output logic [2*IN_W-1:0]      mag,
   output logic                   done,
   output logic                   busy
);

   localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam int OW = 2 * IN_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SQX  = 2'd1,
      SQY  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t          state;
   logic [CW-1:0]   step;
   logic [OW-1:0]   acc;
   logic [IN_W-1:0] ax;
   logic [IN_W-1:0] ay;

   logic [IN_W-1:0] abs_x;
   logic [IN_W-1:0] abs_y;
   logic [IN_W-1:0] operand;
   logic [OW-1:0]   partial;
   logic [OW-1:0]   acc_next;
   logic            last_step;

   // Magnitudes are taken as unsigned IN_W-bit values, so the most negative
   // input maps to 2^(IN_W-1) without overflowing.
   always_comb begin
      abs_x = x[IN_W-1] ? (~x + 1'b1) : x;
      abs_y = y[IN_W-1] ? (~y + 1'b1) : y;
   end

   // One shift-add step of the shared squarer: the operand is multiplied by
   // itself bit by bit, adding the zero-extended operand shifted by the step
   // index whenever that bit of the operand is set.
   always_comb begin
      operand   = (state == SQY) ? ay : ax;
      partial   = '0;
      if (operand[step]) begin
         partial = {{IN_W{1'b0}}, operand} << step;
      end
      acc_next  = acc + partial;
      last_step = (step == CW'(IN_W - 1));
   end

   // Control and datapath registers. The accumulator carries straight from
   // the x pass into the y pass, so the sum of squares falls out of the final
   // step. The DONE cycle also serves as the return to idle: a go sampled on
   // its closing edge starts the next operation, which gives one result every
   // 2*IN_W+1 clocks when go is held high.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         step  <= '0;
         acc   <= '0;
         ax    <= '0;
         ay    <= '0;
         mag   <= '0;
         done  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (go) begin
                  ax    <= abs_x;
                  ay    <= abs_y;
                  acc   <= '0;
                  step  <= '0;
                  busy  <= 1'b1;
                  state <= SQX;
               end else begin
                  state <= IDLE;
               end
            end
            SQX: begin
               acc  <= acc_next;
               step <= step + 1'b1;
               if (last_step) begin
                  step  <= '0;
                  state <= SQY;
               end
            end
            SQY: begin
               acc  <= acc_next;
               step <= step + 1'b1;
               if (last_step) begin
                  step  <= '0;
                  mag   <= acc_next;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE;
               end
            end
            default: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mag_sq.sv
`timescale 1ns/1ps
// tb_mag_sq
// Directed self-checking bench for mag_sq (IN_W = 8). Each scenario task
// drives its own stimulus and compares against hand-computed values; the
// random-pair scenario compares against x*x + y*y computed in the bench.
module tb_mag_sq;

   logic              clk;
   logic              rst_n;
   logic signed [7:0] x;
   logic signed [7:0] y;
   logic              go;
   logic [15:0]       mag;
   logic              done;
   logic              busy;

   int n_cmp;
   int n_fail;

   mag_sq #(.IN_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .x     (x),
      .y     (y),
      .go    (go),
      .mag   (mag),
      .done  (done),
      .busy  (busy)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Starts one operation and watches it: returns the latency in clocks from
   // the accept edge to the first done sample (0 on timeout), the mag seen
   // with done, busy at that moment and how many sampled cycles busy was high.
   task automatic run_op(input logic signed [7:0] xv, input logic signed [7:0] yv,
                         output int lat, output logic [15:0] m,
                         output logic busy_at_done, output int busy_cycles);
      @(negedge clk);
      x  = xv;
      y  = yv;
      go = 1'b1;
      @(posedge clk);
      #1;
      go = 1'b0;
      lat = 0;
      m = 16'hxxxx;
      busy_at_done = 1'bx;
      busy_cycles = busy ? 1 : 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = k;
            m = mag;
            busy_at_done = busy;
            break;
         end
         if (busy) busy_cycles++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      go = 1'b0;
      x = '0;
      y = '0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (mag !== 16'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_mag: got %0d expected 0", mag);
      end
      n_cmp++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_done: got %b expected 0", done);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_busy: got %b expected 0", busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int lat;
      logic [15:0] m;
      logic bd;
      int bc;
      run_op(8'sd3, 8'sd4, lat, m, bd, bc);
      n_cmp++;
      if (lat !== 16) begin
         n_fail++;
         $display("[TB] FAIL basic_latency: got %0d expected 16", lat);
      end
      n_cmp++;
      if (m !== 16'd25) begin
         n_fail++;
         $display("[TB] FAIL basic_mag: got %0d expected 25", m);
      end
      n_cmp++;
      if (bc !== 16) begin
         n_fail++;
         $display("[TB] FAIL basic_busy_cycles: got %0d expected 16", bc);
      end
      n_cmp++;
      if (bd !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL basic_busy_at_done: got %b expected 0", bd);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL basic_done_width: got %b expected 0", done);
      end
      n_cmp++;
      if (mag !== 16'd25) begin
         n_fail++;
         $display("[TB] FAIL basic_mag_hold: got %0d expected 25", mag);
      end
   endtask

   task automatic test_extremes();
      logic signed [7:0] xs [3] = '{-8'sd128, 8'sd127, 8'sd0};
      logic signed [7:0] ys [3] = '{-8'sd128, -8'sd1, 8'sd0};
      logic [15:0]       ev [3] = '{16'd32768, 16'd16130, 16'd0};
      int lat;
      logic [15:0] m;
      logic bd;
      int bc;
      for (int i = 0; i < 3; i++) begin
         run_op(xs[i], ys[i], lat, m, bd, bc);
         n_cmp++;
         if (lat !== 16 || m !== ev[i]) begin
            n_fail++;
            $display("[TB] FAIL extreme_%0d: got mag %0d lat %0d expected mag %0d lat 16",
                     i, m, lat, ev[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int first;
      int prev;
      int ndone;
      int bad_gap;
      int bad_mag;
      first = 0;
      prev = 0;
      ndone = 0;
      bad_gap = 0;
      bad_mag = 0;
      @(negedge clk);
      x  = 8'sd5;
      y  = 8'sd12;
      go = 1'b1;
      // Cycle 1 is the accept edge; results are expected at 17, 34 and 51.
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk);
         #1;
         if (done) begin
            ndone++;
            if (first == 0) first = c;
            else if (c - prev != 17) bad_gap++;
            prev = c;
            if (mag !== 16'd169) bad_mag++;
         end
      end
      go = 1'b0;
      n_cmp++;
      if (first !== 17) begin
         n_fail++;
         $display("[TB] FAIL b2b_first: got %0d expected 17", first);
      end
      n_cmp++;
      if (ndone !== 3 || bad_gap !== 0) begin
         n_fail++;
         $display("[TB] FAIL b2b_rate: got %0d results (%0d bad gaps) expected 3 at 17-clock spacing",
                  ndone, bad_gap);
      end
      n_cmp++;
      if (bad_mag !== 0) begin
         n_fail++;
         $display("[TB] FAIL b2b_mag: got %0d wrong results expected 0", bad_mag);
      end
      repeat (20) @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL b2b_settle: got busy %b expected 0", busy);
      end
   endtask

   task automatic test_input_change();
      int lat;
      int changed;
      logic [15:0] held;
      held = mag;
      lat = 0;
      changed = 0;
      @(negedge clk);
      x  = -8'sd7;
      y  = 8'sd9;
      go = 1'b1;
      @(posedge clk);
      #1;
      go = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         if (mag !== held) changed++;
         x = 8'($urandom);
         y = 8'($urandom);
         // Also pulse go while busy: it must not start anything.
         go = k[0];
         @(posedge clk);
         #1;
         if (done) begin
            lat = k;
            break;
         end
      end
      go = 1'b0;
      n_cmp++;
      if (changed !== 0) begin
         n_fail++;
         $display("[TB] FAIL change_hold: got %0d cycles with mag changed expected 0", changed);
      end
      n_cmp++;
      if (lat !== 16 || mag !== 16'd130) begin
         n_fail++;
         $display("[TB] FAIL change_mag: got mag %0d lat %0d expected mag 130 lat 16", mag, lat);
      end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0 || mag !== 16'd130) begin
         n_fail++;
         $display("[TB] FAIL change_no_restart: got busy %b mag %0d expected busy 0 mag 130", busy, mag);
      end
   endtask

   task automatic test_mid_reset();
      int seen;
      int lat;
      logic [15:0] m;
      logic bd;
      int bc;
      seen = 0;
      @(negedge clk);
      x  = 8'sd3;
      y  = 8'sd4;
      go = 1'b1;
      @(posedge clk);
      #1;
      go = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      n_cmp++;
      if (mag !== 16'd0 || done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL midreset_state: got mag %0d done %b busy %b expected 0 0 0",
                  mag, done, busy);
      end
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      n_cmp++;
      if (seen !== 0) begin
         n_fail++;
         $display("[TB] FAIL midreset_no_pulse: got %0d pulses expected 0", seen);
      end
      run_op(8'sd1, 8'sd1, lat, m, bd, bc);
      n_cmp++;
      if (lat !== 16 || m !== 16'd2) begin
         n_fail++;
         $display("[TB] FAIL midreset_fresh: got mag %0d lat %0d expected mag 2 lat 16", m, lat);
      end
   endtask

   task automatic test_random();
      int lat;
      logic [15:0] m;
      logic bd;
      int bc;
      int xi;
      int yi;
      int expv;
      logic signed [7:0] xv;
      logic signed [7:0] yv;
      for (int i = 0; i < 40; i++) begin
         xv = 8'($urandom);
         yv = 8'($urandom);
         xi = int'(xv);
         yi = int'(yv);
         expv = xi * xi + yi * yi;
         run_op(xv, yv, lat, m, bd, bc);
         n_cmp++;
         if (lat !== 16 || int'(m) !== expv) begin
            n_fail++;
            $display("[TB] FAIL random_%0d x=%0d y=%0d: got mag %0d lat %0d expected mag %0d lat 16",
                     i, xi, yi, m, lat, expv);
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      test_reset();
      test_basic();
      test_extremes();
      test_back_to_back();
      test_input_change();
      test_mid_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
